// File: rtl/systolic_sequencer_pkg.sv
// Shared types and constants for the systolic array sequencer: lane element
// formats for the west/north feeds and the south-edge drain, plus the FSM states.
package systolic_sequencer_pkg;

    localparam int ARRAY_N    = 4;
    localparam int ADDR_W     = 8;
    localparam int DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        FLUSH,
        DRAIN,
        DONE
    } seq_state_t;

    typedef logic [DATA_WIDTH-1:0] elem_t;

    // One operand on an array edge; last marks the final inner-product term.
    typedef struct packed {
        elem_t data;
        logic  last;
    } matrix_data_t;

    // One result element leaving the bottom PE row; en means the PE holds a result.
    typedef struct packed {
        elem_t data;
        logic  en;
    } drain_data_t;

    typedef elem_t        [ARRAY_N-1:0] data_t;
    typedef matrix_data_t [ARRAY_N-1:0] matrix_vec_t;
    typedef drain_data_t  [ARRAY_N-1:0] drain_vec_t;

    function automatic matrix_data_t make_operand(input elem_t d, input logic last);
        matrix_data_t m;
        m.data = d;
        m.last = last;
        return m;
    endfunction

endpackage

// File: rtl/systolic_sequencer_skew_buffer.sv
// Diagonal skew for one array edge: lane i is delayed by i shift stages plus a
// common output register, so lane i leaves i+1 cycles after it enters.
module systolic_sequencer_skew_buffer #(
    parameter int  N      = 4,
    parameter type lane_t = logic
) (
    input  logic              clk,
    input  logic              rst,
    input  lane_t [N-1:0]     lane_i,
    output lane_t [N-1:0]     lane_o
);

    for (genvar i = 0; i < N; i++) begin : g_lane
        if (i == 0) begin : g_direct
            lane_t out_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_q <= '0;
                end else begin
                    out_q <= lane_i[i];
                end
            end

            assign lane_o[i] = out_q;
        end else begin : g_delay
            lane_t [i-1:0] sr_q;
            lane_t         out_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sr_q  <= '0;
                    out_q <= '0;
                end else begin
                    sr_q[0] <= lane_i[i];
                    for (int m = 1; m < i; m++) begin
                        sr_q[m] <= sr_q[m-1];
                    end
                    out_q <= sr_q[i-1];
                end
            end

            assign lane_o[i] = out_q;
        end
    end

endmodule

// File: rtl/systolic_sequencer.sv
// Runs one N x N output-stationary matrix multiply: streams skewed A/B operands into
// the array edges, waits for the pipeline to flush, then drains result rows bottom-first.
module systolic_sequencer
    import systolic_sequencer_pkg::*;
#(
    parameter int N      = ARRAY_N,
    parameter int ADDR_W = systolic_sequencer_pkg::ADDR_W,
    parameter int PE_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       k_len,
    output logic                    busy,
    output logic                    done,
    output logic                    a_rd_en,
    output logic [ADDR_W-1:0]       a_rd_addr,
    input  elem_t [N-1:0]           a_rd_data,
    output logic                    b_rd_en,
    output logic [ADDR_W-1:0]       b_rd_addr,
    input  elem_t [N-1:0]           b_rd_data,
    output matrix_data_t [N-1:0]    row_o,
    output matrix_data_t [N-1:0]    col_o,
    input  drain_data_t [N-1:0]     drain_i,
    output logic                    drain_shift_o,
    output logic                    res_valid,
    input  logic                    res_ready,
    output elem_t [N-1:0]           res_data
);

    // Last operand needs 2N-1 hops to cross the array plus the feed skew.
    localparam int FLUSH_CYCLES = 3 * N - 1 + PE_LAT;
    localparam int FL_W         = $clog2(FLUSH_CYCLES);
    localparam int ROW_W        = (N > 1) ? $clog2(N) : 1;

    seq_state_t          state_q;
    logic [ADDR_W-1:0]   k_q;
    logic [ADDR_W-1:0]   k_len_q;
    logic [FL_W-1:0]     flush_q;
    logic [ROW_W-1:0]    row_q;
    logic                rd_vld_q;
    logic                rd_last_q;

    logic                feed_last;
    logic                all_en;
    logic                res_xfer;
    matrix_data_t [N-1:0] row_in;
    matrix_data_t [N-1:0] col_in;

    assign feed_last = (k_q == (k_len_q - 1'b1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            k_len_q   <= '0;
            flush_q   <= '0;
            row_q     <= '0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            rd_vld_q  <= (state_q == FEED);
            rd_last_q <= (state_q == FEED) && feed_last;
            case (state_q)
                IDLE: begin
                    if (start && (k_len != '0)) begin
                        k_len_q <= k_len;
                        k_q     <= '0;
                        state_q <= FEED;
                    end
                end
                FEED: begin
                    if (feed_last) begin
                        k_q     <= '0;
                        flush_q <= '0;
                        state_q <= FLUSH;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_q == FL_W'(FLUSH_CYCLES - 1)) begin
                        row_q   <= '0;
                        state_q <= DRAIN;
                    end else begin
                        flush_q <= flush_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (res_xfer) begin
                        if (row_q == ROW_W'(N - 1)) begin
                            state_q <= DONE;
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign a_rd_en   = (state_q == FEED);
    assign b_rd_en   = (state_q == FEED);
    assign a_rd_addr = k_q;
    assign b_rd_addr = k_q;

    // Buffer outputs hold stale data between reads, so only pass them when a read returned.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            row_in[i] = '0;
            col_in[i] = '0;
            if (rd_vld_q) begin
                row_in[i] = make_operand(a_rd_data[i], rd_last_q);
                col_in[i] = make_operand(b_rd_data[i], rd_last_q);
            end
        end
    end

    systolic_sequencer_skew_buffer #(
        .N      (N),
        .lane_t (matrix_data_t)
    ) u_row_skew (
        .clk    (clk),
        .rst    (rst),
        .lane_i (row_in),
        .lane_o (row_o)
    );

    systolic_sequencer_skew_buffer #(
        .N      (N),
        .lane_t (matrix_data_t)
    ) u_col_skew (
        .clk    (clk),
        .rst    (rst),
        .lane_i (col_in),
        .lane_o (col_o)
    );

    always_comb begin
        all_en = 1'b1;
        for (int j = 0; j < N; j++) begin
            all_en   = all_en & drain_i[j].en;
            res_data[j] = drain_i[j].data;
        end
    end

    assign res_valid     = (state_q == DRAIN) && all_en;
    assign res_xfer      = res_valid && res_ready;
    assign drain_shift_o = res_xfer;

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer: operand buffers and a bottom-row drain
// model surround the DUT; each scenario task checks cycle-exact outputs.
module tb_systolic_sequencer;
    import systolic_sequencer_pkg::*;

    localparam int N = ARRAY_N;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [ADDR_W-1:0]    k_len;
    logic                 busy, done;
    logic                 a_rd_en, b_rd_en;
    logic [ADDR_W-1:0]    a_rd_addr, b_rd_addr;
    elem_t [N-1:0]        a_rd_data = '1;
    elem_t [N-1:0]        b_rd_data = '1;
    matrix_data_t [N-1:0] row_o, col_o;
    drain_data_t [N-1:0]  drain_i;
    logic                 drain_shift_o, res_valid, res_ready;
    elem_t [N-1:0]        res_data;

    int errors = 0;
    int checks = 0;
    int shifts = 0;
    logic [N-1:0] en_mask;

    always #5 clk = ~clk;

    systolic_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .k_len         (k_len),
        .busy          (busy),
        .done          (done),
        .a_rd_en       (a_rd_en),
        .a_rd_addr     (a_rd_addr),
        .a_rd_data     (a_rd_data),
        .b_rd_en       (b_rd_en),
        .b_rd_addr     (b_rd_addr),
        .b_rd_data     (b_rd_data),
        .row_o         (row_o),
        .col_o         (col_o),
        .drain_i       (drain_i),
        .drain_shift_o (drain_shift_o),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data)
    );

    function automatic elem_t a_val(input int i, input int k);
        return elem_t'(((i + 1) << 4) + k + 1);
    endfunction

    function automatic elem_t b_val(input int j, input int k);
        return elem_t'(((j + 5) << 4) + k + 1);
    endfunction

    function automatic elem_t drain_val(input int r, input int j);
        return elem_t'(8'h80 + (r << 4) + j);
    endfunction

    // Single-port buffers: 1-cycle read latency, output holds between reads.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (a_rd_en) a_rd_data[i] <= a_val(i, int'(a_rd_addr));
            if (b_rd_en) b_rd_data[i] <= b_val(i, int'(b_rd_addr));
        end
    end

    // Bottom row of the array: each shift brings the next row up to the south edge.
    always @(posedge clk) begin
        if (start) shifts <= 0;
        else if (drain_shift_o) shifts <= shifts + 1;
    end

    always_comb begin
        for (int j = 0; j < N; j++) begin
            drain_i[j].data = drain_val(N - 1 - shifts, j);
            drain_i[j].en   = en_mask[j];
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input int klen);
        start = 1'b1;
        k_len = ADDR_W'(klen);
        next_cycle();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        #1;
        checks++;
        if ({busy, done, a_rd_en, b_rd_en, drain_shift_o, res_valid} !== 6'b0)
            begin errors++; $display("FAIL reset_ctrl: got %b want 000000", {busy, done, a_rd_en, b_rd_en, drain_shift_o, res_valid}); end
        checks++;
        if (a_rd_addr !== '0 || b_rd_addr !== '0)
            begin errors++; $display("FAIL reset_addr: got %h/%h want 0/0", a_rd_addr, b_rd_addr); end
        checks++;
        if (row_o !== '0 || col_o !== '0)
            begin errors++; $display("FAIL reset_feeds: got %h/%h want 0", row_o, col_o); end
        rst = 1'b0;
        next_cycle();
    endtask

    // k_len=3, ready=1: skew timing, flush length, 4 drains, done, idle.
    task automatic test_full_run();
        res_ready = 1'b1;
        en_mask   = '1;
        start_op(3);
        for (int c = 1; c <= 21; c++) begin
            #1;
            checks++;
            if (a_rd_en !== (c <= 3) || b_rd_en !== (c <= 3))
                begin errors++; $display("FAIL full_rd_en cyc %0d: got %b%b want %b", c, a_rd_en, b_rd_en, (c <= 3)); end
            if (c <= 3) begin
                checks++;
                if (a_rd_addr !== ADDR_W'(c - 1) || b_rd_addr !== ADDR_W'(c - 1))
                    begin errors++; $display("FAIL full_rd_addr cyc %0d: got %0d/%0d want %0d", c, a_rd_addr, b_rd_addr, c - 1); end
            end
            for (int i = 0; i < N; i++) begin
                int e = c - 3 - i;
                matrix_data_t er = '0;
                matrix_data_t ec = '0;
                if (e >= 0 && e < 3) begin
                    er.data = a_val(i, e); er.last = (e == 2);
                    ec.data = b_val(i, e); ec.last = (e == 2);
                end
                checks++;
                if (row_o[i] !== er) begin errors++; $display("FAIL full_row_o[%0d] cyc %0d: got %h want %h", i, c, row_o[i], er); end
                checks++;
                if (col_o[i] !== ec) begin errors++; $display("FAIL full_col_o[%0d] cyc %0d: got %h want %h", i, c, col_o[i], ec); end
            end
            checks++;
            if (busy !== (c <= 20) || done !== (c == 20))
                begin errors++; $display("FAIL full_busy_done cyc %0d: got %b%b want %b%b", c, busy, done, (c <= 20), (c == 20)); end
            checks++;
            if (res_valid !== (c >= 16 && c <= 19) || drain_shift_o !== (c >= 16 && c <= 19))
                begin errors++; $display("FAIL full_drain cyc %0d: got v%b s%b want %b", c, res_valid, drain_shift_o, (c >= 16 && c <= 19)); end
            if (c >= 16 && c <= 19) begin
                for (int j = 0; j < N; j++) begin
                    checks++;
                    if (res_data[j] !== drain_val(N - 1 - (c - 16), j))
                        begin errors++; $display("FAIL full_res_data[%0d] cyc %0d: got %h want %h", j, c, res_data[j], drain_val(N - 1 - (c - 16), j)); end
                end
            end
            next_cycle();
        end
    endtask

    // k_len=2: DRAIN from cycle 15; ready low for cycles 16..20 while row 2 is presented.
    task automatic test_backpressure();
        en_mask = '1;
        start_op(2);
        for (int c = 1; c <= 26; c++) begin
            logic exp_v, exp_s;
            int   exp_row;
            res_ready = !(c >= 16 && c <= 20);
            #1;
            exp_v   = (c >= 15 && c <= 23);
            exp_s   = exp_v && res_ready;
            exp_row = (c == 15) ? 3 : (c <= 21) ? 2 : (c == 22) ? 1 : 0;
            checks++;
            if (res_valid !== exp_v || drain_shift_o !== exp_s)
                begin errors++; $display("FAIL bp_handshake cyc %0d: got v%b s%b want v%b s%b", c, res_valid, drain_shift_o, exp_v, exp_s); end
            if (exp_v) begin
                checks++;
                if (res_data[0] !== drain_val(exp_row, 0) || res_data[N-1] !== drain_val(exp_row, N - 1))
                    begin errors++; $display("FAIL bp_res_data cyc %0d: got %h want row %0d", c, res_data, exp_row); end
            end
            checks++;
            if (done !== (c == 24) || busy !== (c <= 24))
                begin errors++; $display("FAIL bp_busy_done cyc %0d: got %b%b want %b%b", c, busy, done, (c <= 24), (c == 24)); end
            next_cycle();
        end
        res_ready = 1'b1;
    endtask

    // k_len=1: DRAIN from cycle 14; lane 1 enable low for cycles 14..16.
    task automatic test_drain_enables();
        res_ready = 1'b1;
        start_op(1);
        for (int c = 1; c <= 22; c++) begin
            logic exp_v;
            en_mask = (c >= 14 && c <= 16) ? 4'b1101 : 4'b1111;
            #1;
            exp_v = (c >= 17 && c <= 20);
            checks++;
            if (res_valid !== exp_v || drain_shift_o !== exp_v)
                begin errors++; $display("FAIL en_handshake cyc %0d: got v%b s%b want %b", c, res_valid, drain_shift_o, exp_v); end
            if (exp_v) begin
                checks++;
                if (res_data[1] !== drain_val(3 - (c - 17), 1))
                    begin errors++; $display("FAIL en_res_data cyc %0d: got %h want %h", c, res_data[1], drain_val(3 - (c - 17), 1)); end
            end
            if (c == 3 || c == 6) begin
                checks++;
                if (row_o[(c == 3) ? 0 : 3] !== make_operand(a_val((c == 3) ? 0 : 3, 0), 1'b1))
                    begin errors++; $display("FAIL en_single_last cyc %0d: got %h", c, row_o[(c == 3) ? 0 : 3]); end
            end
            checks++;
            if (done !== (c == 21))
                begin errors++; $display("FAIL en_done cyc %0d: got %b want %b", c, done, (c == 21)); end
            next_cycle();
        end
        en_mask = '1;
    endtask

    task automatic test_kzero();
        start_op(0);
        for (int c = 1; c <= 4; c++) begin
            #1;
            checks++;
            if (busy !== 1'b0 || a_rd_en !== 1'b0 || b_rd_en !== 1'b0)
                begin errors++; $display("FAIL kzero cyc %0d: got busy %b rd %b%b want 0", c, busy, a_rd_en, b_rd_en); end
            next_cycle();
        end
    endtask

    // start with k_len=5 during FEED must not change the running k_len=2 job.
    task automatic test_start_while_busy();
        res_ready = 1'b1;
        start_op(2);
        for (int c = 1; c <= 21; c++) begin
            start = (c == 1);
            k_len = (c == 1) ? ADDR_W'(5) : ADDR_W'(0);
            #1;
            checks++;
            if (a_rd_en !== (c <= 2))
                begin errors++; $display("FAIL swb_rd_en cyc %0d: got %b want %b", c, a_rd_en, (c <= 2)); end
            if (c == 4) begin
                checks++;
                if (row_o[0] !== make_operand(a_val(0, 1), 1'b1))
                    begin errors++; $display("FAIL swb_last cyc %0d: got %h want %h", c, row_o[0], make_operand(a_val(0, 1), 1'b1)); end
            end
            checks++;
            if (done !== (c == 19) || busy !== (c <= 19))
                begin errors++; $display("FAIL swb_busy_done cyc %0d: got %b%b want %b%b", c, busy, done, (c <= 19), (c == 19)); end
            next_cycle();
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid();
        int done_cyc = -1;
        int xfers    = 0;
        res_ready = 1'b1;
        start_op(3);
        next_cycle();
        checks++;
        if (a_rd_addr !== ADDR_W'(1))
            begin errors++; $display("FAIL rstmid_addr: got %0d want 1", a_rd_addr); end
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || a_rd_en !== 1'b0)
            begin errors++; $display("FAIL rstmid_async: got busy %b rd %b want 0", busy, a_rd_en); end
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || row_o !== '0 || col_o !== '0)
                begin errors++; $display("FAIL rstmid_quiet cyc %0d: got busy %b done %b row %h col %h", c, busy, done, row_o, col_o); end
            next_cycle();
        end
        start_op(2);
        for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
            #1;
            if (drain_shift_o) xfers++;
            if (done) done_cyc = c;
            next_cycle();
        end
        checks++;
        if (done_cyc != 19)
            begin errors++; $display("FAIL rstmid_rerun_done: got cycle %0d want 19 (-1 = timeout)", done_cyc); end
        checks++;
        if (xfers != N)
            begin errors++; $display("FAIL rstmid_rerun_xfers: got %0d want %0d", xfers, N); end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        k_len     = '0;
        res_ready = 1'b0;
        en_mask   = '0;
        test_reset();
        test_full_run();
        next_cycle();
        test_backpressure();
        next_cycle();
        test_drain_enables();
        next_cycle();
        test_kzero();
        test_start_while_busy();
        next_cycle();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/systolic_sequencer.md
Name: systolic_sequencer

Overview:
- Control FSM that runs one matrix multiply on the N x N output-stationary PE array.
- Reads A-row and B-column operand vectors from two single-port operand buffers, skews them into the array's west and north edges as matrix_data_t, and flags `last` on the final inner-product element.
- After the pipeline flushes, drains the N result rows out of the array's south edge onto a valid/ready result stream.

Parameters:
- N, 4, array dimension: PE rows = PE columns = operand lanes.
- ADDR_W, 8, operand buffer address width; maximum k_len = 2^ADDR_W-1.
- PE_LAT, 1, PE register latency per hop margin, used in the flush count.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  launch pulse, sampled in IDLE only.
- k_len  in  ADDR_W  inner dimension, sampled with start.
- busy  out  1  high from FEED through DONE.
- done  out  1  one-cycle completion pulse.
- a_rd_en  out  1  A buffer read enable.
- a_rd_addr  out  ADDR_W  A buffer address (= k).
- a_rd_data  in  N*DATA_WIDTH  A column vector k, lane i = row i; valid 1 cycle after a_rd_en.
- b_rd_en  out  1  B buffer read enable.
- b_rd_addr  out  ADDR_W  B buffer address (= k).
- b_rd_data  in  N*DATA_WIDTH  B row vector k, lane j = column j; 1-cycle latency.
- row_o  out  N*$bits(matrix_data_t)  west-edge feed, lane i to PE row i.
- col_o  out  N*$bits(matrix_data_t)  north-edge feed, lane j to PE column j.
- drain_i  in  N*$bits(drain_data_t)  bottom-row drain outputs of the array.
- drain_shift_o  out  1  pulse: array shifts results down one row.
- res_valid  out  1  result row valid.
- res_ready  in  1  result row accepted.
- res_data  out  N*DATA_WIDTH  drain_i data fields, lane j = column j.

Behaviour:
- Reset: all state to IDLE. busy, done, rd_en, drain_shift_o and res_valid are 0. Addresses are 0. All row_o/col_o lanes are {data 0, last 0}. Skew registers are cleared. Reset mid-operation aborts the multiply immediately with no done.
- Bubbles: every lane not carrying an operand drives {0, 0}. A zero operand contributes nothing to the MAC.
- IDLE:
  - start=1 with k_len!=0: latch k_len, clear k, go to FEED.
  - start with k_len==0: ignored.
- FEED:
  - Each cycle assert a_rd_en and b_rd_en with address k, then k++.
  - After issuing k = k_len-1, go to FLUSH.
  - Lasts exactly k_len cycles. The first read is in the cycle after start.
- Skew timing:
  - The element read in cycle t appears on row_o[i] and col_o[i] in cycle t+2+i: 1 read latency, 1 output register, i skew registers.
  - `last` is 1 only on element k_len-1, per lane.
- FLUSH:
  - Counts FLUSH_CYCLES = 3*N-1+PE_LAT cycles, then goes to DRAIN.
  - No reads occur in this state.
  - Feeds return to bubbles once skewed data has exited.
- DRAIN:
  - res_valid = AND of all drain_i enable bits.
  - res_data mirrors drain_i data combinationally.
  - On res_valid && res_ready, pulse drain_shift_o in the same cycle and increment the row counter.
  - res_valid with !res_ready: hold. drain_shift_o stays 0 and res_data must remain stable.
  - Rows leave bottom-first: the first transfer is array row N-1, the last is row 0.
  - After the N-th transfer go to DONE.
- DONE: done=1 for one cycle, busy still 1, then IDLE. start in this cycle is ignored.
- start while busy: ignored, with no effect on k_len.
- Arithmetic: k counter is ADDR_W bits and never wraps, since k_len <= 2^ADDR_W-1. FLUSH and row counters are sized with $clog2. Data is passed through unmodified with no width change.

Decomposition:
- Shared package gains:
  - ARRAY_N and ADDR_W localparams.
  - A seq_state_t enum {IDLE, FEED, FLUSH, DRAIN, DONE}.
  - Packed vector typedefs for N-lane data_t, matrix_data_t and drain_data_t.
- Sub-module skew_buffer (parameters N, element type): per-lane i-deep shift registers plus an output register. It is instantiated twice, for rows and for columns. The FSM, counters and drain handshake live in systolic_sequencer.

Test Plan:
- N=4, k_len=3, start at cycle 0:
  - reads at addr 0,1,2 in cycles 1-3.
  - row_o[0] shows A[0][0..2] in cycles 3-5 with last on cycle 5.
  - row_o[3] shows A[3][0..2] in cycles 6-8 with last on cycle 8.
  - All other cycles are {0,0}; col_o behaves the same.
- Full run, N=4, k_len=3, res_ready=1, drain_i enables high:
  - FLUSH lasts 12 cycles.
  - 4 consecutive res_valid transfers with 4 drain_shift_o pulses.
  - done 1 cycle after the 4th transfer, then busy=0.
- Drain backpressure: hold res_ready=0 for 5 cycles on row 2. res_valid stays 1, res_data is stable, no drain_shift_o, row counter unchanged. Release: transfer completes and drain continues.
- Drain enables: clear drain_i enable on lane 1 for 3 cycles → res_valid=0 and no shift during those cycles.
- start with k_len=0 → no reads, busy stays 0. start during FEED with a new k_len → ignored; original k_len honoured.
- Assert rst during FEED at k=1 → next cycle busy=0, feeds {0,0}, no done. A fresh start with k_len=2 then completes normally.
